// File: rtl/matrix_framebuf_if.sv
`default_nettype none
//==============================================================================
// Module   : matrix_framebuf_if
// Brief    : Pixel-source, swap-control and scanner-read signals of the
//            double-buffered HUB75 frame store.
// Revision : 1.0
//==============================================================================
interface matrix_framebuf_if #(
    parameter int COL_BITS = 6,
    parameter int ROW_BITS = 6
);
    logic                wr_en;
    logic [COL_BITS-1:0] wr_x;
    logic [ROW_BITS-1:0] wr_y;
    logic [2:0]          wr_rgb;
    logic                clear_req;
    logic [2:0]          clear_rgb;
    logic                busy;
    logic                swap_req;
    logic                frame_end;
    logic                swap_pending;
    logic                swap_done;
    logic                rd_en;
    logic [ROW_BITS-2:0] rd_row;
    logic [COL_BITS-1:0] rd_col;
    logic [2:0]          rgb1;
    logic [2:0]          rgb2;
    logic                front;

    modport master (
        output wr_en, wr_x, wr_y, wr_rgb, clear_req, clear_rgb,
        output swap_req, frame_end, rd_en, rd_row, rd_col,
        input  busy, swap_pending, swap_done, rgb1, rgb2, front
    );

    modport slave (
        input  wr_en, wr_x, wr_y, wr_rgb, clear_req, clear_rgb,
        input  swap_req, frame_end, rd_en, rd_row, rd_col,
        output busy, swap_pending, swap_done, rgb1, rgb2, front
    );
endinterface
`default_nettype wire

// File: rtl/matrix_framebuf.sv
`default_nettype none
//==============================================================================
// Module   : matrix_framebuf
// Brief    : Double-buffered 3-bit pixel store feeding the HUB75 scanner;
//            buffers exchange only on a scanner frame boundary.
// Revision : 1.0
//==============================================================================
module matrix_framebuf #(
    parameter int COL_BITS = 6,
    parameter int ROW_BITS = 6
) (
    input  wire logic        clk,
    input  wire logic        rst,
    matrix_framebuf_if.slave bus
);
    localparam int c_addr_bits = COL_BITS + ROW_BITS - 1;
    localparam int c_depth     = 1 << c_addr_bits;
    localparam logic [c_addr_bits-1:0] c_last_addr = {c_addr_bits{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [c_addr_bits-1:0]  r_cnt, w_cnt_nxt;
    logic [2:0]              r_clr_rgb, w_clr_rgb_nxt;
    logic                    r_front;
    logic                    r_swap_pending;
    logic                    r_swap_done;
    logic [2:0]              r_rgb1;
    logic [2:0]              r_rgb2;

    logic                    w_busy;
    logic                    w_wr_take;
    logic                    w_wr_lower;
    logic                    w_swap_go;
    logic [c_addr_bits-1:0]  w_wr_addr;
    logic [c_addr_bits-1:0]  w_rd_addr;
    logic [c_addr_bits-1:0]  w_mem_addr;
    logic [2:0]              w_mem_din;
    logic [1:0][2:0]         w_rd_up;
    logic [1:0][2:0]         w_rd_lo;

    assign w_busy     = (r_state == S_CLEAR);
    assign w_wr_take  = bus.wr_en && !w_busy && !bus.clear_req;
    assign w_wr_lower = bus.wr_y[ROW_BITS-1];
    assign w_wr_addr  = {bus.wr_y[ROW_BITS-2:0], bus.wr_x};
    assign w_rd_addr  = {bus.rd_row, bus.rd_col};
    // A clear and a pixel write are mutually exclusive, so one port serves both.
    assign w_mem_addr = w_busy ? r_cnt : w_wr_addr;
    assign w_mem_din  = w_busy ? r_clr_rgb : bus.wr_rgb;
    assign w_swap_go  = bus.frame_end && (r_swap_pending || bus.swap_req)
                        && !w_busy && !bus.clear_req;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_clr_rgb_nxt = r_clr_rgb;
        case (r_state)
            S_IDLE: begin
                if (bus.clear_req) begin
                    w_state_nxt   = S_CLEAR;
                    w_cnt_nxt     = '0;
                    w_clr_rgb_nxt = bus.clear_rgb;
                end
            end
            S_CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_last_addr) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_clr_rgb      <= '0;
            r_front        <= 1'b0;
            r_swap_pending <= 1'b0;
            r_swap_done    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_clr_rgb   <= w_clr_rgb_nxt;
            r_swap_done <= w_swap_go;
            if (w_swap_go) begin
                r_front        <= ~r_front;
                r_swap_pending <= 1'b0;
            end else if (bus.swap_req) begin
                r_swap_pending <= 1'b1;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [2:0] r_mem_up [c_depth];
        logic [2:0] r_mem_lo [c_depth];
        logic       w_back;

        assign w_back = (r_front != 1'(b));

        always_ff @(posedge clk) begin
            if (w_back && (w_busy || (w_wr_take && !w_wr_lower))) begin
                r_mem_up[w_mem_addr] <= w_mem_din;
            end
            if (w_back && (w_busy || (w_wr_take && w_wr_lower))) begin
                r_mem_lo[w_mem_addr] <= w_mem_din;
            end
        end

        assign w_rd_up[b] = r_mem_up[w_rd_addr];
        assign w_rd_lo[b] = r_mem_lo[w_rd_addr];
    end

    // Bank select uses front as it stands in the read cycle, before any swap edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb1 <= '0;
            r_rgb2 <= '0;
        end else if (bus.rd_en) begin
            r_rgb1 <= w_rd_up[r_front];
            r_rgb2 <= w_rd_lo[r_front];
        end
    end

    assign bus.busy         = w_busy;
    assign bus.swap_pending = r_swap_pending;
    assign bus.swap_done    = r_swap_done;
    assign bus.front        = r_front;
    assign bus.rgb1         = r_rgb1;
    assign bus.rgb2         = r_rgb2;
endmodule
`default_nettype wire

// File: tb/tb_matrix_framebuf.sv
`default_nettype none
//==============================================================================
// Module   : tb_matrix_framebuf
// Brief    : Directed self-checking bench for matrix_framebuf.
// Revision : 1.0
//==============================================================================
module tb_matrix_framebuf;
    localparam int COL_BITS = 6;
    localparam int ROW_BITS = 6;
    localparam int c_depth  = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    matrix_framebuf_if #(.COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS)) bus ();

    matrix_framebuf #(.COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_px(input logic [5:0] x, input logic [5:0] y, input logic [2:0] c);
        bus.wr_en = 1'b1; bus.wr_x = x; bus.wr_y = y; bus.wr_rgb = c;
        tick;
        bus.wr_en = 1'b0;
    endtask

    task automatic rd_px(input logic [4:0] row, input logic [5:0] col);
        bus.rd_en = 1'b1; bus.rd_row = row; bus.rd_col = col;
        tick;
        bus.rd_en = 1'b0;
    endtask

    task automatic do_clear(input logic [2:0] c, input string tag);
        int n;
        bus.clear_rgb = c; bus.clear_req = 1'b1;
        tick;
        bus.clear_req = 1'b0;
        n = 0;
        while (bus.busy && n < 4096) begin
            n++;
            tick;
        end
        check(tag, n, c_depth);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int errs;
        bus.wr_en = 0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_rgb = '0;
        bus.clear_req = 0; bus.clear_rgb = '0; bus.swap_req = 0; bus.frame_end = 0;
        bus.rd_en = 0; bus.rd_row = '0; bus.rd_col = '0;
        repeat (3) tick;
        rst = 1'b0;
        tick;
        check("rst_rgb", {26'd0, bus.rgb1, bus.rgb2}, 0);
        check("rst_front", bus.front, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_pending", bus.swap_pending, 0);
        check("rst_done", bus.swap_done, 0);

        // Zero both banks; bank 1 then simultaneous swap_req + frame_end.
        do_clear(3'b000, "clr0_busy_len");
        bus.swap_req = 1; bus.frame_end = 1;
        tick;
        bus.swap_req = 0; bus.frame_end = 0;
        check("simul_done", bus.swap_done, 1);
        check("simul_front", bus.front, 1);
        check("simul_pending", bus.swap_pending, 0);
        tick;
        check("done_pulse_one", bus.swap_done, 0);

        // Bank 0, then a swap held pending for 100 cycles.
        do_clear(3'b000, "clr1_busy_len");
        bus.swap_req = 1;
        tick;
        bus.swap_req = 0;
        repeat (100) tick;
        check("hold_pending", bus.swap_pending, 1);
        check("hold_front", bus.front, 1);
        bus.swap_req = 1;
        tick;
        bus.swap_req = 0;
        bus.frame_end = 1;
        tick;
        bus.frame_end = 0;
        check("pend_front", bus.front, 0);
        check("pend_done", bus.swap_done, 1);
        check("pend_cleared", bus.swap_pending, 0);
        bus.frame_end = 1;
        tick;
        bus.frame_end = 0;
        check("one_toggle_front", bus.front, 0);
        check("one_toggle_done", bus.swap_done, 0);

        // Pixel writes land in the back bank only.
        wr_px(6'd5, 6'd3, 3'b100);
        wr_px(6'd5, 6'd35, 3'b011);
        rd_px(5'd3, 6'd5);
        check("rd_noswap", {26'd0, bus.rgb1, bus.rgb2}, 6'b000000);
        bus.swap_req = 1;
        tick;
        bus.swap_req = 0;
        check("req_pending", bus.swap_pending, 1);
        bus.frame_end = 1; bus.rd_en = 1; bus.rd_row = 5'd3; bus.rd_col = 6'd5;
        tick;
        bus.frame_end = 0; bus.rd_en = 0;
        check("swap_done", bus.swap_done, 1);
        check("swap_front", bus.front, 1);
        check("rd_swapcycle_old", {26'd0, bus.rgb1, bus.rgb2}, 6'b000000);
        rd_px(5'd3, 6'd5);
        check("rd_after_swap", {26'd0, bus.rgb1, bus.rgb2}, 6'b100011);
        bus.rd_col = 6'd6;
        tick;
        check("rd_hold", {26'd0, bus.rgb1, bus.rgb2}, 6'b100011);

        // Clear bank 0 with 010; write on clear_req cycle and mid-clear are dropped.
        bus.clear_rgb = 3'b010; bus.clear_req = 1;
        bus.wr_en = 1; bus.wr_x = 6'd9; bus.wr_y = 6'd1; bus.wr_rgb = 3'b101;
        tick;
        bus.clear_req = 0; bus.wr_en = 0;
        n = 0;
        while (bus.busy && n < 4096) begin
            n++;
            if (n == 31) begin
                check("midclr_front", bus.front, 1);
                check("midclr_done", bus.swap_done, 0);
                check("midclr_pending", bus.swap_pending, 1);
            end
            bus.wr_en = (n == 10); bus.wr_x = 6'd7; bus.wr_y = 6'd0; bus.wr_rgb = 3'b111;
            bus.swap_req = (n == 20);
            bus.frame_end = (n == 30);
            tick;
        end
        bus.wr_en = 0; bus.swap_req = 0; bus.frame_end = 0;
        check("clr2_busy_len", n, c_depth);
        check("postclr_pending", bus.swap_pending, 1);
        bus.frame_end = 1;
        tick;
        bus.frame_end = 0;
        check("postclr_front", bus.front, 0);
        check("postclr_done", bus.swap_done, 1);
        rd_px(5'd0, 6'd7);
        check("drop_midclr", {26'd0, bus.rgb1, bus.rgb2}, 6'b010010);
        rd_px(5'd1, 6'd9);
        check("drop_reqcycle", {26'd0, bus.rgb1, bus.rgb2}, 6'b010010);
        errs = 0;
        for (int i = 0; i <= c_depth; i++) begin
            if (i < c_depth) begin
                bus.rd_en = 1;
                {bus.rd_row, bus.rd_col} = 11'(i);
            end else begin
                bus.rd_en = 0;
            end
            tick;
            if ({bus.rgb1, bus.rgb2} !== 6'b010010) errs++;
        end
        check("clear_scan_errs", errs, 0);

        // Reset in the middle of a clear with a swap pending.
        bus.swap_req = 1; bus.frame_end = 1;
        tick;
        bus.swap_req = 0; bus.frame_end = 0;
        check("pre_rst_front", bus.front, 1);
        bus.clear_rgb = 3'b111; bus.clear_req = 1;
        tick;
        bus.clear_req = 0;
        bus.swap_req = 1;
        tick;
        bus.swap_req = 0;
        repeat (498) tick;
        check("pre_rst_busy", bus.busy, 1);
        check("pre_rst_pending", bus.swap_pending, 1);
        rst = 1'b1;
        tick;
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_pending", bus.swap_pending, 0);
        check("rst_mid_front", bus.front, 0);
        check("rst_mid_rgb", {26'd0, bus.rgb1, bus.rgb2}, 0);
        check("rst_mid_done", bus.swap_done, 0);
        rst = 1'b0;
        tick;
        check("post_rst_busy", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/matrix_framebuf.md
# matrix_framebuf

Double-buffered pixel store that sits directly upstream of the HUB75 scan state machine and supplies its per-clock `rgb1`/`rgb2` colour pair. A pixel source writes single pixels or bulk-clears into the back buffer. The scanner reads the front buffer by row-pair and column. A swap request exchanges the buffers only at a scanner frame boundary, so the panel never shows a torn frame.

## Interface
- `COL_BITS`, default 6: column address width; panel has 2^COL_BITS columns.
- `ROW_BITS`, default 6: full row address width; panel has 2^ROW_BITS rows, scanned as 2^(ROW_BITS-1) row pairs.
- `clk` in 1: single clock for all logic (25 MHz domain of the scanner).
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: write strobe for one pixel into the back buffer.
- `wr_x` in COL_BITS: write column.
- `wr_y` in ROW_BITS: write row. MSB=0 selects the upper half; MSB=1 selects the lower half.
- `wr_rgb` in 3: pixel colour {R,G,B}.
- `clear_req` in 1: pulse; fill the entire back buffer with `clear_rgb`.
- `clear_rgb` in 3: fill colour, sampled on the `clear_req` cycle.
- `busy` out 1: clear in progress.
- `swap_req` in 1: pulse; request a front/back exchange.
- `frame_end` in 1: one-cycle strobe from the scanner after the last row pair is latched.
- `swap_pending` out 1: swap requested, not yet performed.
- `swap_done` out 1: one-cycle pulse on the cycle the swap takes effect.
- `rd_en` in 1: scanner read strobe.
- `rd_row` in ROW_BITS-1: row-pair address (drives A..E downstream).
- `rd_col` in COL_BITS: column address.
- `rgb1` out 3: front-buffer pixel at (rd_col, rd_row).
- `rgb2` out 3: front-buffer pixel at (rd_col, rd_row + 2^(ROW_BITS-1)).
- `front` out 1: index of the buffer currently displayed.

## Operation
- Storage: two banks. Each bank is split into an upper-half array and a lower-half array of 2^(COL_BITS+ROW_BITS-1) x 3 bits, so one read yields both `rgb1` and `rgb2`.
- Array address is {row[ROW_BITS-2:0], col}.
- Memory is zero at configuration and is not affected by `rst`.
- Reset values: `front`=0, `busy`=0, `swap_pending`=0, `swap_done`=0, `rgb1`=`rgb2`=0, clear counter=0.
- Pixel write:
  - Taken when `wr_en`=1, `busy`=0 and `clear_req`=0. It lands in bank `~front` as `front` stood at the start of that cycle.
  - A write during `busy`, or in the same cycle as `clear_req`, is dropped.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when `clear_req`=1. Latch `clear_rgb` and zero the counter.
  - In CLEAR, each cycle writes the latched colour to address `counter` in both half-arrays of bank `~front`, then increments the counter.
  - CLEAR -> IDLE after address 2^(COL_BITS+ROW_BITS-1)-1 is written.
  - `clear_req` while in CLEAR is ignored.
- Swap:
  - `swap_req`=1 sets `swap_pending`. A repeat request while pending is absorbed.
  - The swap executes on any cycle where `frame_end`=1, (`swap_pending` or `swap_req`) is true, and `busy`=0 and `clear_req`=0.
  - On execution: toggle `front`, clear `swap_pending`, pulse `swap_done`.
  - A `frame_end` during a clear leaves the swap pending until a later `frame_end` with `busy`=0.
- Read: on `rd_en`=1, register both half-array outputs of bank `front`. Outputs hold while `rd_en`=0.

## Timing
- Read latency is 1 cycle: address at cycle t gives `rgb1`/`rgb2` valid from t+1. This is compatible with block-RAM inference.
- A read at the swap cycle t uses the old `front`. A read at t+1 uses the new `front`.
- A write at cycle t is visible to the display only after a subsequent swap.
- Clear timing:
  - `clear_req` at t gives `busy`=1 from t+1 through t+N, where N = 2^(COL_BITS+ROW_BITS-1) (2048 by default).
  - `busy`=0 at t+N+1.
  - The first fill write occurs at t+1 and the last at t+N.
- Swap timing: `front` and `swap_done` change at the edge ending the executing `frame_end` cycle. `swap_pending` falls on the same edge.
- `rst` mid-clear or mid-pending aborts immediately to the reset values. Partially cleared memory is left as is.

## Test plan
- Reset, then read (0,0): expect `rgb1`=`rgb2`=0, `front`=0, `busy`=0.
- Write (x=5, y=3, 3'b100) and (x=5, y=35, 3'b011). Read with no swap: expect 0/0. Swap_req, then frame_end: expect `swap_done` pulse, `front`=1, and a read of row 3 col 5 returning `rgb1`=100, `rgb2`=011 one cycle after `rd_en`.
- Swap_req with no frame_end for 100 cycles: expect `swap_pending`=1 and `front` unchanged. Frame_end: swap occurs. A second swap_req while pending gives exactly one toggle.
- Clear_req with `clear_rgb`=3'b010:
  - Expect `busy` high for exactly 2048 cycles.
  - A wr_en mid-clear is dropped.
  - A frame_end with swap pending mid-clear does not swap.
  - After busy falls, the next frame_end swaps and every address reads 010/010.
- Simultaneous `swap_req` + `frame_end` with `busy`=0: expect the swap on that same cycle.
- Assert `rst` 500 cycles into a clear with a swap pending: expect `busy`=0, `swap_pending`=0, `front`=0, and outputs 0 on the next cycle.
